// File: rtl/avalon_multi_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : avalon_multi_timer_pkg
// Purpose  : Register offsets and bit positions shared by the multi-channel
//            interval timer and its channel sub-module.
// Revision : 1.0  initial release
// ============================================================================
package avalon_multi_timer_pkg;

  // Per-channel register offsets (address[2:0])
  localparam logic [2:0] c_OFF_STATUS   = 3'd0;
  localparam logic [2:0] c_OFF_CONTROL  = 3'd1;
  localparam logic [2:0] c_OFF_PERIOD_L = 3'd2;
  localparam logic [2:0] c_OFF_PERIOD_H = 3'd3;
  localparam logic [2:0] c_OFF_SNAP_L   = 3'd4;
  localparam logic [2:0] c_OFF_SNAP_H   = 3'd5;
  localparam logic [2:0] c_OFF_PRESCALE = 3'd6;
  localparam logic [2:0] c_OFF_RSVD     = 3'd7;

  // CONTROL bit positions
  localparam int c_CTRL_ITO   = 0;
  localparam int c_CTRL_CONT  = 1;
  localparam int c_CTRL_START = 2;
  localparam int c_CTRL_STOP  = 3;

  // STATUS bit positions
  localparam int c_STAT_TO  = 0;
  localparam int c_STAT_RUN = 1;

endpackage
`default_nettype wire

// File: rtl/avalon_multi_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : avalon_multi_timer_if
// Purpose  : Avalon-MM slave port of the multi-channel timer plus its
//            interrupt outputs.
// Revision : 1.0  initial release
// ============================================================================
interface avalon_multi_timer_if #(
  parameter int NUM_CH = 4
) ();
  localparam int ADDR_W = 3 + $clog2(NUM_CH);

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [15:0]       writedata;
  logic [15:0]       readdata;
  logic              irq;
  logic [NUM_CH-1:0] irq_ch;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq, irq_ch
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq, irq_ch
  );
endinterface
`default_nettype wire

// File: rtl/avalon_multi_timer_timer_channel.sv
`default_nettype none
// ============================================================================
// Module   : timer_channel
// Purpose  : One timer channel: period, prescaler, down-counter, snapshot,
//            control and timeout status, with its own read mux.
// Revision : 1.0  initial release
// ============================================================================
module timer_channel
  import avalon_multi_timer_pkg::*;
#(
  parameter int          COUNT_W      = 32,
  parameter int          PRESCALE_W   = 8,
  parameter logic [31:0] RESET_PERIOD = 32'h927BF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_wr_status,
  input  logic        i_wr_control,
  input  logic        i_wr_period_l,
  input  logic        i_wr_period_h,
  input  logic        i_wr_snap,
  input  logic        i_wr_prescale,
  input  logic [15:0] i_wdata,
  input  logic [2:0]  i_offset,
  output logic [15:0] o_rdata,
  output logic        o_irq
);
  localparam logic [COUNT_W-1:0] c_RST_PERIOD = RESET_PERIOD[COUNT_W-1:0];

  logic [COUNT_W-1:0]    r_period;
  logic [COUNT_W-1:0]    r_count;
  logic [COUNT_W-1:0]    r_snap;
  logic [PRESCALE_W-1:0] r_presc;
  logic [PRESCALE_W-1:0] r_pcnt;
  logic [3:0]            r_ctrl;
  logic                  r_run;
  logic                  r_to;
  logic                  r_pend;   // force reload owed from a period write

  logic w_start, w_stop, w_wr_period, w_tick, w_cnt_en, w_timeout;
  logic [31:0] w_per32, w_snap32;

  assign w_start     = i_wr_control & i_wdata[c_CTRL_START];
  assign w_stop      = i_wr_control & i_wdata[c_CTRL_STOP];
  assign w_wr_period = i_wr_period_l | i_wr_period_h;
  // ">=" keeps the prescaler from running away if PRESCALE shrinks mid-count
  assign w_tick      = r_run && (r_pcnt >= r_presc);
  // Period writes (and the reload that follows) and a lone STOP freeze the counter
  assign w_cnt_en    = w_tick && !w_wr_period && !r_pend && !(w_stop && !w_start);
  assign w_timeout   = w_cnt_en && (r_count == '0);
  assign w_per32     = 32'(r_period);
  assign w_snap32    = 32'(r_snap);
  assign o_irq       = r_to & r_ctrl[c_CTRL_ITO];

  // Channel state: register writes, prescaler, counter, RUN and TO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period <= c_RST_PERIOD;
      r_count  <= c_RST_PERIOD;
      r_snap   <= '0;
      r_presc  <= '0;
      r_pcnt   <= '0;
      r_ctrl   <= '0;
      r_run    <= 1'b0;
      r_to     <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      if (i_wr_prescale) r_presc <= i_wdata[PRESCALE_W-1:0];
      if (i_wr_control)  r_ctrl  <= i_wdata[3:0];
      if (i_wr_period_l) r_period[15:0] <= i_wdata;
      if (i_wr_period_h) r_period[COUNT_W-1:16] <= i_wdata[COUNT_W-17:0];
      if (i_wr_snap)     r_snap  <= r_count;
      r_pend <= w_wr_period;

      if (w_start || r_pend)
        r_pcnt <= '0;
      else if (r_run)
        r_pcnt <= w_tick ? '0 : r_pcnt + PRESCALE_W'(1);

      if (r_pend)
        r_count <= r_period;
      else if (w_cnt_en)
        r_count <= (r_count == '0) ? r_period : r_count - COUNT_W'(1);

      // START beats STOP; a one-shot stops on its own timeout
      if (w_start)
        r_run <= 1'b1;
      else if (w_stop || w_wr_period)
        r_run <= 1'b0;
      else if (w_timeout && !r_ctrl[c_CTRL_CONT])
        r_run <= 1'b0;

      // A timeout in the same cycle as a STATUS write is not lost
      if (w_timeout)
        r_to <= 1'b1;
      else if (i_wr_status)
        r_to <= 1'b0;
    end
  end

  // Register read mux for this channel
  always_comb begin
    o_rdata = '0;
    case (i_offset)
      c_OFF_STATUS: begin
        o_rdata[c_STAT_RUN] = r_run;
        o_rdata[c_STAT_TO]  = r_to;
      end
      c_OFF_CONTROL:  o_rdata[3:0] = r_ctrl;
      c_OFF_PERIOD_L: o_rdata = w_per32[15:0];
      c_OFF_PERIOD_H: o_rdata = w_per32[31:16];
      c_OFF_SNAP_L:   o_rdata = w_snap32[15:0];
      c_OFF_SNAP_H:   o_rdata = w_snap32[31:16];
      c_OFF_PRESCALE: o_rdata = 16'(r_presc);
      default:        o_rdata = '0;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/avalon_multi_timer.sv
`default_nettype none
// ============================================================================
// Module   : avalon_multi_timer
// Purpose  : NUM_CH independent interval timers behind one 16-bit Avalon-MM
//            slave; decodes {channel, offset}, registers read data, and
//            drives per-channel and aggregate interrupts.
// Revision : 1.0  initial release
// ============================================================================
module avalon_multi_timer
  import avalon_multi_timer_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          COUNT_W      = 32,
  parameter int          PRESCALE_W   = 8,
  parameter logic [31:0] RESET_PERIOD = 32'h927BF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  avalon_multi_timer_if.slave  bus
);
  localparam int ADDR_W = 3 + $clog2(NUM_CH);

  logic [3:0]        w_ch;
  logic [2:0]        w_off;
  logic              w_wr;
  logic [15:0]       w_rd [NUM_CH];
  logic [15:0]       w_rsel;
  logic [NUM_CH-1:0] w_irq;
  logic [15:0]       r_readdata;

  assign w_off = bus.address[2:0];
  assign w_wr  = bus.chipselect & ~bus.write_n;

  // A single-channel build has no channel field in the address
  if (ADDR_W > 3) begin : g_ch_field
    assign w_ch = 4'(bus.address[ADDR_W-1:3]);
  end else begin : g_ch_single
    assign w_ch = '0;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic w_sel;
    assign w_sel = w_wr && (w_ch == 4'(i));

    timer_channel #(
      .COUNT_W      (COUNT_W),
      .PRESCALE_W   (PRESCALE_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_ch (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_wr_status   (w_sel && (w_off == c_OFF_STATUS)),
      .i_wr_control  (w_sel && (w_off == c_OFF_CONTROL)),
      .i_wr_period_l (w_sel && (w_off == c_OFF_PERIOD_L)),
      .i_wr_period_h (w_sel && (w_off == c_OFF_PERIOD_H)),
      .i_wr_snap     (w_sel && ((w_off == c_OFF_SNAP_L) || (w_off == c_OFF_SNAP_H))),
      .i_wr_prescale (w_sel && (w_off == c_OFF_PRESCALE)),
      .i_wdata       (bus.writedata),
      .i_offset      (w_off),
      .o_rdata       (w_rd[i]),
      .o_irq         (w_irq[i])
    );
  end

  // Select the addressed channel; unimplemented channel indices read 0
  always_comb begin
    w_rsel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_ch == 4'(i)) w_rsel = w_rd[i];
    end
  end

  // Read data is registered every clock, independent of chipselect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_readdata <= '0;
    else          r_readdata <= w_rsel;
  end

  assign bus.readdata = r_readdata;
  assign bus.irq_ch   = w_irq;
  assign bus.irq      = |w_irq;
endmodule
`default_nettype wire

// File: tb/tb_avalon_multi_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_multi_timer
// Purpose  : Self-checking bench for avalon_multi_timer (3 channels so that
//            channel index NUM_CH is addressable).
// Revision : 1.0  initial release
// ============================================================================
module tb_avalon_multi_timer;
  localparam int NUM_CH     = 3;
  localparam int COUNT_W    = 32;
  localparam int PRESCALE_W = 8;
  localparam int AW         = 3 + $clog2(NUM_CH);

  typedef struct {
    int          ch;
    int          off;
    bit          wr;
    logic [15:0] data;
    logic [15:0] exp;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vt[$];
  logic [15:0] d;

  always #5 clk = ~clk;

  avalon_multi_timer_if #(.NUM_CH(NUM_CH)) bus ();

  avalon_multi_timer #(
    .NUM_CH       (NUM_CH),
    .COUNT_W      (COUNT_W),
    .PRESCALE_W   (PRESCALE_W),
    .RESET_PERIOD (32'h927BF)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One write cycle: strobe is seen at the posedge between the two negedges
  task automatic bus_write(input int ch, input int off, input logic [15:0] data);
    @(negedge clk);
    bus.address    = AW'(ch * 8 + off);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = data;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  // Read without chipselect: readdata follows the address one clock later
  task automatic bus_read(input int ch, input int off, output logic [15:0] data);
    @(negedge clk);
    bus.address    = AW'(ch * 8 + off);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    @(negedge clk);
    data = bus.readdata;
  endtask

  initial begin
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    repeat (3) @(negedge clk);
    check("rst_irq", bus.irq, 1'b0);
    check("rst_irq_ch", bus.irq_ch, 3'b000);
    check("rst_readdata", bus.readdata, 16'h0);
    reset_n = 1'b1;

    // ---------------- register table ----------------
    vt.push_back('{0, 2, 1'b0, 16'h0000, 16'h27BF, "rst_perl"});
    vt.push_back('{0, 3, 1'b0, 16'h0000, 16'h0009, "rst_perh"});
    vt.push_back('{0, 0, 1'b0, 16'h0000, 16'h0000, "rst_st0"});
    vt.push_back('{1, 0, 1'b0, 16'h0000, 16'h0000, "rst_st1"});
    vt.push_back('{2, 0, 1'b0, 16'h0000, 16'h0000, "rst_st2"});
    vt.push_back('{0, 1, 1'b0, 16'h0000, 16'h0000, "rst_ctrl"});
    vt.push_back('{0, 6, 1'b0, 16'h0000, 16'h0000, "rst_presc"});
    vt.push_back('{0, 4, 1'b0, 16'h0000, 16'h0000, "rst_snapl"});
    vt.push_back('{2, 6, 1'b1, 16'h01AB, 16'h0000, ""});
    vt.push_back('{2, 6, 1'b0, 16'h0000, 16'h00AB, "presc_trunc"});
    vt.push_back('{2, 7, 1'b1, 16'hFFFF, 16'h0000, ""});
    vt.push_back('{2, 7, 1'b0, 16'h0000, 16'h0000, "reserved"});
    vt.push_back('{1, 1, 1'b1, 16'h0002, 16'h0000, ""});
    vt.push_back('{1, 1, 1'b0, 16'h0000, 16'h0002, "ctrl_store"});
    vt.push_back('{1, 1, 1'b1, 16'h0000, 16'h0000, ""});
    vt.push_back('{2, 2, 1'b1, 16'h1234, 16'h0000, ""});
    vt.push_back('{2, 3, 1'b1, 16'hABCD, 16'h0000, ""});
    vt.push_back('{2, 2, 1'b0, 16'h0000, 16'h1234, "per_l"});
    vt.push_back('{2, 3, 1'b0, 16'h0000, 16'hABCD, "per_h"});
    vt.push_back('{2, 4, 1'b1, 16'h0000, 16'h0000, ""});
    vt.push_back('{2, 4, 1'b0, 16'h0000, 16'h1234, "reload_snapl"});
    vt.push_back('{2, 5, 1'b0, 16'h0000, 16'hABCD, "reload_snaph"});
    vt.push_back('{3, 2, 1'b1, 16'h5555, 16'h0000, ""});
    vt.push_back('{3, 2, 1'b0, 16'h0000, 16'h0000, "oob_perl"});
    vt.push_back('{3, 0, 1'b0, 16'h0000, 16'h0000, "oob_status"});
    vt.push_back('{0, 2, 1'b0, 16'h0000, 16'h27BF, "oob_ch0_kept"});
    vt.push_back('{1, 2, 1'b0, 16'h0000, 16'h27BF, "oob_ch1_kept"});

    foreach (vt[i]) begin
      if (vt[i].wr) begin
        bus_write(vt[i].ch, vt[i].off, vt[i].data);
      end else begin
        bus_read(vt[i].ch, vt[i].off, d);
        check(vt[i].name, d, vt[i].exp);
      end
    end
    check("tbl_irq", bus.irq, 1'b0);

    // ---------------- ch1 continuous, period 4, prescale 0 ----------------
    bus_write(1, 2, 16'd4);
    bus_write(1, 3, 16'd0);
    bus_write(1, 1, 16'h0007);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("ch1_to_k%0d", k), bus.irq_ch[1], (k == 5));
    end
    check("irq_agg", bus.irq, 1'b1);
    bus_read(1, 0, d);
    check("ch1_status", d, 16'h0003);
    bus_write(1, 0, 16'h0000);
    check("ch1_clr", bus.irq_ch[1], 1'b0);
    @(negedge clk);
    check("ch1_to_again", bus.irq_ch[1], 1'b1);
    check("ch0_quiet", bus.irq_ch[0], 1'b0);
    // STATUS clear lands exactly on the next timeout edge
    repeat (3) @(negedge clk);
    bus_write(1, 0, 16'h0000);
    check("clr_vs_timeout", bus.irq_ch[1], 1'b1);
    bus_write(1, 1, 16'h0008);
    bus_write(1, 0, 16'h0000);
    bus_read(1, 0, d);
    check("ch1_stopped", d, 16'h0000);

    // ---------------- ch2 one-shot, period 2, prescale 3 ----------------
    bus_write(2, 2, 16'd2);
    bus_write(2, 3, 16'd0);
    bus_write(2, 6, 16'd3);
    bus_write(2, 1, 16'h0005);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("ch2_to_k%0d", k), bus.irq_ch[2], (k == 12));
    end
    bus_read(2, 0, d);
    check("ch2_oneshot_status", d, 16'h0001);
    bus_write(2, 4, 16'h0000);
    bus_read(2, 4, d);
    check("ch2_reloaded", d, 16'd2);
    bus_write(2, 0, 16'h0000);

    // ---------------- ch0 period 1000: snapshot and STOP ----------------
    bus_write(0, 2, 16'd1000);
    bus_write(0, 3, 16'd0);
    bus_write(0, 1, 16'h0006);
    repeat (98) @(negedge clk);
    bus_write(0, 4, 16'h0000);
    bus_write(0, 1, 16'h000A);
    bus_read(0, 4, d);
    check("snap_900", (d >= 16'd899 && d <= 16'd901), 1'b1);
    bus_write(0, 4, 16'h0000);
    bus_read(0, 4, d);
    check("stop_frozen_a", d, 16'd899);
    repeat (50) @(negedge clk);
    bus_write(0, 5, 16'h0000);
    bus_read(0, 4, d);
    check("stop_frozen_b", d, 16'd899);
    bus_read(0, 0, d);
    check("stop_status", d, 16'h0000);

    // START+STOP together: START wins
    bus_write(0, 1, 16'h000C);
    bus_read(0, 0, d);
    check("start_wins", d, 16'h0002);

    // PERIOD_H mid-count: RUN clears, counter takes the new period
    bus_write(0, 3, 16'h0001);
    bus_read(0, 0, d);
    check("perh_run_clr", d, 16'h0000);
    bus_write(0, 4, 16'h0000);
    bus_read(0, 4, d);
    check("perh_snapl", d, 16'h03E8);
    bus_read(0, 5, d);
    check("perh_snaph", d, 16'h0001);

    // ---------------- asynchronous reset mid-count ----------------
    bus_write(1, 1, 16'h0007);
    repeat (8) @(negedge clk);
    check("pre_reset_irq", bus.irq, 1'b1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_irq", bus.irq, 1'b0);
    check("async_rst_irq_ch", bus.irq_ch, 3'b000);
    check("async_rst_rdata", bus.readdata, 16'h0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(1, 2, d);
    check("rst2_perl", d, 16'h27BF);
    bus_read(1, 0, d);
    check("rst2_status", d, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/avalon_multi_timer.md
# avalon_multi_timer

Parametrised multi-channel Avalon-MM interval timer: NUM_CH independent down-counters of COUNT_W bits, each with its own period, prescaler, snapshot, control and timeout status behind one 16-bit slave port. Successor to the single-channel system clock timer; sits on the system interconnect and drives one aggregate IRQ plus a per-channel IRQ vector for the interrupt controller.

## Interface
- NUM_CH, 4: number of channels, 1..8.
- COUNT_W, 32: counter/period width, 17..32.
- PRESCALE_W, 8: prescaler width, 1..16.
- RESET_PERIOD, 32'h927BF: reset value of every channel's period and counter (truncated to COUNT_W).
- clk  in  1  system clock; sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3+clog2(NUM_CH)  {channel, offset}; offset = address[2:0].
- chipselect  in  1  slave select.
- write_n  in  1  active-low write.
- writedata  in  16  write data.
- readdata  out  16  registered read data.
- irq  out  1  OR of irq_ch.
- irq_ch  out  NUM_CH  per-channel interrupt.

## Operation
- Offsets per channel: 0 STATUS {RUN,TO} (write clears TO), 1 CONTROL [3:0] = {STOP,START,CONT,ITO}, 2 PERIOD_L, 3 PERIOD_H (bits COUNT_W-17:0, upper bits read 0), 4 SNAP_L, 5 SNAP_H, 6 PRESCALE, 7 reserved (reads 0, writes ignored). Channel index ≥ NUM_CH reads 0, writes ignored.
- Write strobe = chipselect & ~write_n & matching address. CONTROL stores all 4 bits; START/STOP also act as one-cycle strobes.
- Tick: prescale counter counts 0..PRESCALE while RUN; tick when it equals PRESCALE, then returns to 0. PRESCALE=0 gives a tick every clock.
- On tick while RUN: counter==0 → reload period, set TO, clear RUN if CONT=0; else decrement. Period P gives timeout every (P+1)(PRESCALE+1) clocks.
- PERIOD_L/H write: next cycle force-reload counter with new period, clear prescale counter, clear RUN.
- START strobe: set RUN, clear prescale counter, counter not reloaded. STOP strobe: clear RUN, counter holds.
- Snapshot: any write to SNAP_L or SNAP_H latches the counter value; reads return latched value.
- irq_ch[i] = TO[i] & ITO[i]; irq = |irq_ch.

## Timing
- Reset: counters and periods = RESET_PERIOD, PRESCALE = 0, CONTROL = 0, RUN = 0, TO = 0, snapshots 0, readdata = 0, irq = irq_ch = 0.
- Read latency 1: readdata valid the cycle after the address is presented; readdata updates every clock regardless of chipselect.
- TO set and irq_ch asserted the cycle after the zero-tick edge.
- Simultaneous: START+STOP in one write → START wins; STATUS clear and timeout same cycle → TO stays set (no lost event); period write and tick same cycle → force reload wins, no TO; START with pending force reload → RUN set, counter loads new period.
- Wrap: counter never underflows; one-shot stops with counter reloaded to period.
- Reset mid-count: all state returns to reset values asynchronously, no partial outputs.

## Structure
- Package avalon_multi_timer_pkg: offset constants (STATUS..PRESCALE), control bit positions, status bit positions.
- Sub-module timer_channel: one channel's registers, prescaler, counter, status; parent decodes address, generates strobes, muxes readdata, ORs IRQs.

## Test plan
- Reset, read ch0 PERIOD_L/H → 16'h27BF / 16'h0009; all STATUS = 0, irq = 0.
- Ch1: PERIOD=4, PRESCALE=0, CONTROL=4'b0111 → TO set every 5 clocks, irq_ch[1] and irq high until STATUS write; ch0 unaffected.
- Ch2: PERIOD=2, PRESCALE=3, CONTROL=4'b0101 (one-shot) → single TO after 12 clocks, RUN clears, counter = 2.
- Ch0 running at PERIOD=1000: write SNAP_L after 100 clocks → SNAP reads 900±1; write STOP → counter frozen across 50 clocks.
- STATUS clear issued on timeout cycle → TO remains 1; START+STOP together → RUN = 1.
- Write PERIOD_H mid-count → RUN = 0, counter = new period next cycle; address to channel NUM_CH → read 0, no state change.
